// File: rtl/coproc_seq.sv
// Command sequencer for the multiply/divide/shift coprocessor: launches one command, polls
// busy, reads back the result cells and status, and returns them as a single response.
module coproc_seq #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MAXPOLL = 255
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [1:0]       req_fmt,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [WIDTH-1:0] req_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [10:0]      cp_sel,
  output logic             cp_go,
  output logic [WIDTH-1:0] cp_a,
  output logic [WIDTH-1:0] cp_b,
  output logic [WIDTH-1:0] cp_c,
  input  logic [WIDTH-1:0] cp_y
);

  if (MAXPOLL < 1 || MAXPOLL > 255) begin : g_bad_maxpoll
    $error("coproc_seq: MAXPOLL must be in 1..255");
  end
  if (WIDTH < 9) begin : g_bad_width
    $error("coproc_seq: WIDTH must cover the status overflow bit 8");
  end

  localparam logic [7:0] MaxPoll = 8'(MAXPOLL);

  localparam logic [1:0] OpMul  = 2'd0;
  localparam logic [1:0] OpDiv  = 2'd1;
  localparam logic [1:0] OpRsvd = 2'd3;

  typedef enum logic [3:0] {
    StIdle,
    StLaunch,
    StPoll,
    StCheck,
    StRdHi,
    StRdLo,
    StRdSt,
    StCap,
    StDone
  } state_e;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [7:0]       poll_cnt_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_hi_q, rsp_lo_q;
  logic             rsp_ovf_q, rsp_err_q;
  logic [10:0]      cp_sel_q;
  logic             cp_go_q;

  // Trigger select: function code 8/9/A in [3:0], shift format in [7:6].
  function automatic logic [10:0] launch_sel(input logic [1:0] op, input logic [1:0] fmt);
    return {3'b000, fmt, 2'b00, 2'b10, op};
  endfunction

  // Result read selects: hi cell at 2/4/6, lo cell one above.
  function automatic logic [10:0] rd_sel(input logic [1:0] op, input logic lo);
    return {8'd0, 2'(op + 2'd1), lo};
  endfunction

  // Outputs are registered: each transition also loads the outputs of the state being entered.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      poll_cnt_q  <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hi_q    <= '0;
      rsp_lo_q    <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      cp_sel_q    <= '0;
      cp_go_q     <= 1'b0;
    end else begin
      cp_go_q  <= 1'b0;
      cp_sel_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (req_ready_q && req_valid) begin
            req_ready_q <= 1'b0;
            op_q        <= req_op;
            a_q         <= req_a;
            b_q         <= req_b;
            c_q         <= req_c;
            poll_cnt_q  <= '0;
            rsp_hi_q    <= '0;
            rsp_lo_q    <= '0;
            rsp_ovf_q   <= 1'b0;
            if (req_op == OpRsvd) begin
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              rsp_err_q <= 1'b0;
              cp_go_q   <= 1'b1;
              cp_sel_q  <= launch_sel(req_op, req_fmt);
              state_q   <= StLaunch;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        StLaunch: begin
          cp_go_q <= 1'b1;
          state_q <= StPoll;
        end
        StPoll: begin
          poll_cnt_q <= poll_cnt_q + 8'd1;
          state_q    <= StCheck;
        end
        StCheck: begin
          if (cp_y == '0) begin
            cp_go_q  <= 1'b1;
            cp_sel_q <= rd_sel(op_q, 1'b0);
            state_q  <= StRdHi;
          end else if (poll_cnt_q < MaxPoll) begin
            cp_go_q <= 1'b1;
            state_q <= StPoll;
          end else begin
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StRdHi: begin
          cp_go_q  <= 1'b1;
          cp_sel_q <= rd_sel(op_q, 1'b1);
          state_q  <= StRdLo;
        end
        StRdLo: begin
          rsp_hi_q <= cp_y;
          cp_go_q  <= 1'b1;
          cp_sel_q <= 11'd1;
          state_q  <= StRdSt;
        end
        StRdSt: begin
          rsp_lo_q <= cp_y;
          state_q  <= StCap;
        end
        StCap: begin
          rsp_ovf_q   <= (op_q == OpDiv) ? cp_y[8] : 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // op_q only distinguishes divide at capture time; mul code kept for readability of rd_sel.
  logic unused_op;
  assign unused_op = (op_q == OpMul);

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_lo    = rsp_lo_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;
  assign cp_sel    = cp_sel_q;
  assign cp_go     = cp_go_q;
  assign cp_a      = a_q;
  assign cp_b      = b_q;
  assign cp_c      = c_q;

endmodule

// File: tb/tb_coproc_seq.sv
// Bench for coproc_seq: a coprocessor stub with programmable busy polls and a response
// scoreboard fed at command issue and drained at the response handshake.
module tb_coproc_seq;

  localparam int unsigned W    = 16;
  localparam int unsigned MAXP = 3;

  logic          clk = 1'b0;
  logic          arstn;
  logic          req_valid, req_ready;
  logic [1:0]    req_op, req_fmt;
  logic [W-1:0]  req_a, req_b, req_c;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_hi, rsp_lo;
  logic          rsp_ovf, rsp_err;
  logic [10:0]   cp_sel;
  logic          cp_go;
  logic [W-1:0]  cp_a, cp_b, cp_c, cp_y;

  always #5 clk = ~clk;

  coproc_seq #(.WIDTH(W), .MAXPOLL(MAXP)) dut (
    .clk(clk), .arstn(arstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_fmt(req_fmt),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .cp_sel(cp_sel), .cp_go(cp_go), .cp_a(cp_a), .cp_b(cp_b), .cp_c(cp_c), .cp_y(cp_y)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference coprocessor arithmetic: {ovf, hi, lo}.
  function automatic logic [32:0] cp_model(input logic [1:0] op, input logic [1:0] fmt,
                                           input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c);
    logic [31:0] d;
    logic [4:0]  sh;
    d  = {a, b};
    sh = c[4:0];
    case (op)
      2'd0: return {1'b0, 32'(a) * 32'(b)};
      2'd1: begin
        if (a >= c) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, 16'(d / 32'(c)), 16'(d % 32'(c))};
      end
      2'd2: begin
        case (fmt)
          2'd0: return {1'b0, d << sh};
          2'd1: return {1'b0, d >> sh};
          2'd2: return {1'b0, 32'($signed(d) >>> sh)};
          default: return {1'b0, (d << sh) | (d >> (6'd32 - {1'b0, sh}))};
        endcase
      end
      default: return 33'd0;
    endcase
  endfunction

  // ---------------- coprocessor stub ----------------
  int          busy_cfg;   // busy polls after a trigger; negative = busy forever
  int          busy_left;
  int          n_polls;
  logic [1:0]  trig_k;
  logic [15:0] res_hi, res_lo;
  logic        st_ovf;     // sticky: only a divide trigger updates it
  logic [32:0] trig_r;
  logic [1:0]  rd_k;
  logic [10:0] sel_log[$];

  assign trig_r = cp_model(cp_sel[1:0], cp_sel[7:6], cp_a, cp_b, cp_c);
  assign rd_k   = 2'(cp_sel[2:1] - 2'd1);

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cp_y      <= '0;
      busy_left <= 0;
      n_polls   <= 0;
      trig_k    <= 2'd3;
      res_hi    <= '0;
      res_lo    <= '0;
      st_ovf    <= 1'b0;
    end else if (cp_go) begin
      sel_log.push_back(cp_sel);
      if (cp_sel[10:8] == 3'd0 && cp_sel[5:4] == 2'd0 && cp_sel[3:0] inside {4'h8, 4'h9, 4'hA}) begin
        res_hi    <= trig_r[31:16];
        res_lo    <= trig_r[15:0];
        trig_k    <= cp_sel[1:0];
        if (cp_sel[1:0] == 2'd1) st_ovf <= trig_r[32];
        busy_left <= busy_cfg;
        n_polls   <= 0;
        cp_y      <= '0;
      end else if (cp_sel == 11'd0) begin
        cp_y    <= (busy_left != 0) ? 16'h0001 : 16'h0000;
        n_polls <= n_polls + 1;
        if (busy_left > 0) busy_left <= busy_left - 1;
      end else if (cp_sel == 11'd1) begin
        cp_y <= {7'd0, st_ovf, 8'h00};
      end else if (cp_sel[10:3] == 8'd0 && cp_sel[2:1] != 2'd0) begin
        if (rd_k == trig_k) cp_y <= cp_sel[0] ? res_lo : res_hi;
        else cp_y <= 16'hDEAD;
      end else begin
        cp_y <= 16'hBAD0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        ovf;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];

  always @(negedge clk) begin : mon
    rsp_t e;
    if (arstn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_hi", 64'(rsp_hi), 64'(e.hi));
        check_eq("rsp_lo", 64'(rsp_lo), 64'(e.lo));
        check_eq("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
        check_eq("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  // Latency counts the accepting edge as clock 1.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] fmt, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] c, input int busy,
                         input int hold, input logic [15:0] eh, input logic [15:0] el,
                         input logic eo, input logic ee, output int lat);
    int n;
    exp_q.push_back('{hi: eh, lo: el, ovf: eo, err: ee});
    busy_cfg  = busy;
    rsp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) check_eq("req_ready_wait", 64'(req_ready), 64'd1);
    sel_log.delete();
    req_op = op; req_fmt = fmt; req_a = a; req_b = b; req_c = c; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = 16'hFFFF; req_b = 16'hFFFF; req_c = 16'hFFFF; req_fmt = 2'd3;
    lat = 1;
    while (!rsp_valid && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid) check_eq("rsp_valid_timeout", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 64'(rsp_valid), 64'd1);
      check_eq("hold_hi", 64'(rsp_hi), 64'(eh));
      check_eq("hold_lo", 64'(rsp_lo), 64'(el));
      check_eq("hold_flags", 64'({rsp_ovf, rsp_err}), 64'({eo, ee}));
      check_eq("hold_req_ready", 64'(req_ready), 64'd0);
      check_eq("hold_cp_go", 64'(cp_go), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    if (hold > 0) check_eq("ready_after_hold", 64'({req_ready, rsp_valid}), 64'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [10:0] mul_sel[5];
  logic [32:0] r;
  int lat, n;
  logic [1:0]  rop, rfmt;
  logic [15:0] ra, rb, rc;

  initial begin
    mul_sel = '{11'h008, 11'h000, 11'h002, 11'h003, 11'h001};
    arstn = 1'b0; req_valid = 1'b0; req_op = '0; req_fmt = '0;
    req_a = '0; req_b = '0; req_c = '0; rsp_ready = 1'b1; busy_cfg = 0;
    #3;
    check_eq("rst_ready_valid", 64'({req_ready, rsp_valid}), 64'd0);
    check_eq("rst_rsp", 64'({rsp_hi, rsp_lo, rsp_ovf, rsp_err}), 64'd0);
    check_eq("rst_cp", 64'({cp_go, cp_sel, cp_a, cp_b, cp_c}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); arstn = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_rst", 64'(req_ready), 64'd1);

    run_cmd(2'd0, 2'd0, 16'h1234, 16'h0010, 16'h0000, 0, 0, 16'h0001, 16'h2340, 1'b0, 1'b0, lat);
    check_eq("mul_latency", 64'(lat), 64'd8);
    check_eq("mul_sel_count", 64'(sel_log.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < sel_log.size()) check_eq("mul_sel_seq", 64'(sel_log[i]), 64'(mul_sel[i]));

    run_cmd(2'd1, 2'd0, 16'h0001, 16'h0000, 16'h0010, 1, 0, 16'h1000, 16'h0000, 1'b0, 1'b0, lat);
    check_eq("div_latency_1busy", 64'(lat), 64'd10);
    run_cmd(2'd1, 2'd0, 16'h0001, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, lat);

    // Status still carries the sticky overflow here; non-divide ops must report ovf=0.
    run_cmd(2'd2, 2'd0, 16'h0000, 16'h8001, 16'h0004, 0, 0, 16'h0008, 16'h0010, 1'b0, 1'b0, lat);
    if (sel_log.size() > 0) check_eq("shift_launch_sel", 64'(sel_log[0]), 64'h00A);
    else check_eq("shift_launch_seen", 64'(sel_log.size()), 64'd1);
    run_cmd(2'd2, 2'd2, 16'h8000, 16'h0000, 16'h0004, 0, 0, 16'hF800, 16'h0000, 1'b0, 1'b0, lat);
    if (sel_log.size() > 0) check_eq("shift_fmt2_sel", 64'(sel_log[0]), 64'h08A);
    else check_eq("shift_fmt2_seen", 64'(sel_log.size()), 64'd1);

    run_cmd(2'd0, 2'd0, 16'h0005, 16'h0006, 16'h0000, -1, 0, 16'h0000, 16'h0000, 1'b0, 1'b1, lat);
    check_eq("timeout_polls", 64'(n_polls), 64'(MAXP));
    check_eq("timeout_latency", 64'(lat), 64'd8);

    run_cmd(2'd0, 2'd0, 16'h00FF, 16'h0101, 16'h0000, 2, 0, 16'h0000, 16'hFFFF, 1'b0, 1'b0, lat);
    check_eq("mul_latency_2busy", 64'(lat), 64'd12);

    run_cmd(2'd3, 2'd1, 16'h1111, 16'h2222, 16'h3333, 0, 0, 16'h0000, 16'h0000, 1'b0, 1'b1, lat);
    check_eq("rsvd_no_cp_go", 64'(sel_log.size()), 64'd0);

    run_cmd(2'd0, 2'd0, 16'h0100, 16'h0100, 16'h0000, 0, 10, 16'h0001, 16'h0000, 1'b0, 1'b0, lat);
    run_cmd(2'd1, 2'd0, 16'h0000, 16'h0064, 16'h000A, 0, 0, 16'h000A, 16'h0000, 1'b0, 1'b0, lat);
    check_eq("b2b_latency", 64'(lat), 64'd8);

    // Reset while polling: no response may ever appear for the aborted command.
    busy_cfg = -1;
    req_op = 2'd0; req_a = 16'h0007; req_b = 16'h0009; req_c = 16'h0000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!(cp_go && cp_sel == 11'd0) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_eq("reached_poll", 64'({cp_go, cp_sel}), 64'h800);
    #1 arstn = 1'b0;
    #1;
    check_eq("arst_ready_valid", 64'({req_ready, rsp_valid}), 64'd0);
    check_eq("arst_rsp", 64'({rsp_hi, rsp_lo, rsp_ovf, rsp_err}), 64'd0);
    check_eq("arst_cp", 64'({cp_go, cp_sel, cp_a, cp_b, cp_c}), 64'd0);
    @(negedge clk); arstn = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_arst", 64'(req_ready), 64'd1);
    run_cmd(2'd0, 2'd0, 16'h0003, 16'h0005, 16'h0000, 0, 0, 16'h0000, 16'h000F, 1'b0, 1'b0, lat);
    check_eq("post_arst_latency", 64'(lat), 64'd8);

    for (int i = 0; i < 8; i++) begin
      rop  = 2'($urandom_range(0, 2));
      rfmt = 2'($urandom_range(0, 3));
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rc   = 16'($urandom);
      r    = cp_model(rop, rfmt, ra, rb, rc);
      run_cmd(rop, rfmt, ra, rb, rc, int'($urandom_range(0, 2)), 0, r[31:16], r[15:0],
              (rop == 2'd1) ? r[32] : 1'b0, 1'b0, lat);
    end

    repeat (2) @(posedge clk);
    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
